mem_host_rsp_model: RTL and testbench

//  Host-memory responder BFM on the downstream side of the 4:1 memory request mux.

---
 rtl/mem_host_rsp_model.sv | 171 +++++++++++++++++
 tb/tb_mem_host_rsp_model.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_host_rsp_model.sv
`default_nettype none
// ============================================================================
// Module   : mem_host_rsp_model
// Brief    : Host-memory responder BFM. Byte-masked beat array, in-order
//            fixed-latency read returns, programmable ready backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module mem_host_rsp_model #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int MASK_WIDTH      = DATA_WIDTH / 8,
    parameter int DEPTH           = 1024,
    parameter int RD_LATENCY      = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int STALL_PERIOD    = 0,
    parameter int STALL_CYCLES    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  wr_cmd_rdy,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [MASK_WIDTH-1:0] wr_datamask,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_cmd_rdy,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_data_vld,
    output logic [31:0]           wr_cnt,
    output logic [31:0]           rd_cnt
);

    localparam int c_off_w = $clog2(MASK_WIDTH);
    localparam int c_idx_w = $clog2(DEPTH);
    localparam int c_sc_w  = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
    localparam int c_out_w = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [c_sc_w-1:0]     r_sc;
    logic [c_sc_w-1:0]     w_sc_next;
    logic                  w_stall_next;
    logic                  r_wr_rdy;
    logic                  r_rd_rdy;
    logic                  w_rd_rdy_next;
    logic [c_out_w-1:0]    r_out;
    logic [c_out_w-1:0]    w_out_next;
    logic [31:0]           r_wr_cnt;
    logic [31:0]           r_rd_cnt;

    logic [c_idx_w-1:0]    w_wr_idx;
    logic [c_idx_w-1:0]    w_rd_idx;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_beat;

    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [DATA_WIDTH-1:0] r_pipe_data [RD_LATENCY];
    logic                  w_vld_now;
    logic                  w_vld_next;

    // Only the beat-index field of each address selects storage.
    logic w_unused_addr;
    assign w_unused_addr = ^{wr_addr, rd_addr};

    assign w_wr_idx = wr_addr[c_off_w +: c_idx_w];
    assign w_rd_idx = rd_addr[c_off_w +: c_idx_w];
    assign w_wr_acc = r_wr_rdy & (|wr_datamask);
    assign w_rd_acc = r_rd_rdy & rd_en;

    always_comb begin
        w_sc_next    = '0;
        w_stall_next = 1'b0;
        if (STALL_PERIOD != 0) begin
            if (r_sc != c_sc_w'(STALL_PERIOD - 1)) begin
                w_sc_next = r_sc + 1'b1;
            end
            w_stall_next = (int'(w_sc_next) >= (STALL_PERIOD - STALL_CYCLES));
        end
    end

    assign w_vld_now = r_pipe_vld[RD_LATENCY-1];

    // Return that will be on the output next cycle; frees its slot for a same-cycle accept.
    if (RD_LATENCY == 1) begin : g_lat_one
        assign w_vld_next = w_rd_acc;
    end else begin : g_lat_multi
        assign w_vld_next = r_pipe_vld[RD_LATENCY-2];
    end

    always_comb begin
        w_out_next = r_out;
        if (w_rd_acc && !w_vld_now) begin
            w_out_next = r_out + 1'b1;
        end else if (!w_rd_acc && w_vld_now) begin
            w_out_next = r_out - 1'b1;
        end
    end

    assign w_rd_rdy_next = !w_stall_next &&
                           ((w_out_next - c_out_w'(w_vld_next)) < c_max_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sc     <= '0;
            r_wr_rdy <= 1'b0;
            r_rd_rdy <= 1'b0;
            r_out    <= '0;
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_sc     <= w_sc_next;
            r_wr_rdy <= !w_stall_next;
            r_rd_rdy <= w_rd_rdy_next;
            r_out    <= w_out_next;
            r_wr_cnt <= r_wr_cnt + {31'd0, w_wr_acc};
            r_rd_cnt <= r_rd_cnt + {31'd0, w_rd_acc};
        end
    end

    // Storage is deliberately outside reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (wr_datamask[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Write-first: a same-cycle write to the read index is merged into the returned beat.
    always_comb begin
        w_rd_beat = r_mem[w_rd_idx];
        if (w_wr_acc && (w_wr_idx == w_rd_idx)) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (wr_datamask[b]) begin
                    w_rd_beat[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_acc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_pipe_data[0] <= w_rd_beat;
        for (int i = 1; i < RD_LATENCY; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
        end
    end

    assign wr_cmd_rdy  = r_wr_rdy;
    assign rd_cmd_rdy  = r_rd_rdy;
    assign rd_data_vld = w_vld_now;
    assign rd_data     = w_vld_now ? r_pipe_data[RD_LATENCY-1] : '0;
    assign wr_cnt      = r_wr_cnt;
    assign rd_cnt      = r_rd_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_host_rsp_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_host_rsp_model
// Brief    : Scoreboard bench for mem_host_rsp_model with a reference array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_host_rsp_model;

    localparam int DW    = 512;
    localparam int AW    = 64;
    localparam int MW    = DW / 8;
    localparam int DEPTH = 1024;
    localparam int LAT   = 8;
    localparam int MAXO  = 4;
    localparam int SP    = 10;
    localparam int SC    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_cmd_rdy;
    logic [DW-1:0] wr_data = '0;
    logic [MW-1:0] wr_datamask = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_cmd_rdy;
    logic [DW-1:0] rd_data;
    logic          rd_data_vld;
    logic [31:0]   wr_cnt;
    logic [31:0]   rd_cnt;

    always #5 clk = ~clk;

    mem_host_rsp_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MASK_WIDTH(MW), .DEPTH(DEPTH),
        .RD_LATENCY(LAT), .MAX_OUTSTANDING(MAXO), .STALL_PERIOD(SP), .STALL_CYCLES(SC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_cmd_rdy(wr_cmd_rdy), .wr_data(wr_data), .wr_datamask(wr_datamask), .wr_addr(wr_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_cmd_rdy(rd_cmd_rdy),
        .rd_data(rd_data), .rd_data_vld(rd_data_vld), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    typedef struct {
        bit [DW-1:0] data;
        int          due;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    bit [DW-1:0] model_mem [DEPTH];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          wr_model = 0;
    int          rd_model = 0;

    // scoreboard-side temporaries
    bit          sb_stall;
    bit          sb_ret;
    bit          sb_exp_wr_rdy;
    bit          sb_exp_rd_rdy;
    int          sb_widx;
    exp_t        sb_e;
    exp_t        mon_e;
    int          mon_cur;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int idx_of(input logic [AW-1:0] a);
        return int'(a[6 +: 10]);
    endfunction

    // Issue side: checks readies and counters against the rules, applies accepted
    // commands to the model and queues the expected return.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_wr_rdy", wr_cmd_rdy, '0);
            check("rst_rd_rdy", rd_cmd_rdy, '0);
            check("rst_vld", rd_data_vld, '0);
            check("rst_rd_data", rd_data, '0);
            check("rst_wr_cnt", wr_cnt, '0);
            check("rst_rd_cnt", rd_cnt, '0);
            exp_q.delete();
            wr_model = 0;
            rd_model = 0;
            cyc = 0;
        end else begin
            sb_stall      = (cyc % SP) >= (SP - SC);
            sb_ret        = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            sb_exp_wr_rdy = (cyc >= 1) && !sb_stall;
            sb_exp_rd_rdy = (cyc >= 1) && !sb_stall && ((exp_q.size() - int'(sb_ret)) < MAXO);
            check("wr_cmd_rdy", wr_cmd_rdy, sb_exp_wr_rdy);
            check("rd_cmd_rdy", rd_cmd_rdy, sb_exp_rd_rdy);
            check("wr_cnt", wr_cnt, 32'(wr_model));
            check("rd_cnt", rd_cnt, 32'(rd_model));
            if (wr_cmd_rdy && (|wr_datamask)) begin
                sb_widx = idx_of(wr_addr);
                for (int b = 0; b < MW; b++) begin
                    if (wr_datamask[b]) model_mem[sb_widx][8*b +: 8] = wr_data[8*b +: 8];
                end
                wr_model++;
            end
            if (rd_en && rd_cmd_rdy) begin
                sb_e.data = model_mem[idx_of(rd_addr)];
                sb_e.due  = cyc + LAT;
                exp_q.push_back(sb_e);
                rd_model++;
            end
            cyc++;
        end
    end

    // Return side: pops and compares whenever the DUT presents a beat.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            mon_cur = cyc - 1;
            if (rd_data_vld) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_return: got vld=1 data %0h want no return at %0t", rd_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("ret_cycle", mon_cur, mon_e.due);
                    check("ret_data", rd_data, mon_e.data);
                end
            end else begin
                check("idle_data", rd_data, '0);
                total++;
                if (exp_q.size() > 0 && exp_q[0].due <= mon_cur) begin
                    bad++;
                    $display("FAIL missed_return: got vld=0 want return due cycle %0d at cycle %0d", exp_q[0].due, mon_cur);
                    void'(exp_q.pop_front());
                end
            end
            check("inflight_cap", exp_q.size() <= MAXO, 1'b1);
        end
    end

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [MW-1:0] rand_mask();
        logic [MW-1:0] m;
        m = '0;
        case ($urandom_range(3))
            0: m = '1;
            1: m[$urandom_range(MW-1)] = 1'b1;
            2: m = {$urandom, $urandom};
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        a[6 +: 10] = 10'($urandom_range(31));
        return a;
    endfunction

    // Hold each request until its ready is seen, then drop it.
    task automatic xfer(input bit do_wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [MW-1:0] wm, input bit do_rd, input logic [AW-1:0] ra);
        bit wp;
        bit rp;
        int guard;
        wp = do_wr;
        rp = do_rd;
        guard = 0;
        wr_addr = wa;
        wr_data = wd;
        wr_datamask = wp ? wm : '0;
        rd_addr = ra;
        rd_en = rp;
        while ((wp || rp) && guard < 100) begin
            @(negedge clk);
            if (wp && wr_cmd_rdy) wp = 1'b0;
            if (rp && rd_cmd_rdy) rp = 1'b0;
            @(posedge clk);
            #1;
            if (!wp) wr_datamask = '0;
            if (!rp) rd_en = 1'b0;
            guard++;
        end
        total++;
        if (wp || rp) begin
            bad++;
            $display("FAIL xfer_timeout: got pending wr=%0d rd=%0d want none", wp, rp);
            wr_datamask = '0;
            rd_en = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL idle_timeout: got %0d reads pending want 0", exp_q.size());
        end
    endtask

    task automatic stream_rd(input int ncyc, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        bit acc;
        a = base;
        rd_addr = a;
        rd_en = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            acc = rd_cmd_rdy;
            @(posedge clk);
            #1;
            if (acc) begin
                a = a + 64;
                rd_addr = a;
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic rand_phase(input int ncyc, input int wr_pct, input int rd_pct);
        bit wp;
        bit rp;
        wp = 1'b0;
        rp = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (!wp && int'($urandom_range(99)) < wr_pct) begin
                wr_addr = rand_addr();
                wr_data = rand_beat();
                wr_datamask = rand_mask();
                wp = |wr_datamask;
            end
            if (!rp && int'($urandom_range(99)) < rd_pct) begin
                rd_addr = rand_addr();
                rd_en = 1'b1;
                rp = 1'b1;
            end
            @(negedge clk);
            if (wp && wr_cmd_rdy) wp = 1'b0;
            if (rp && rd_cmd_rdy) rp = 1'b0;
            @(posedge clk);
            #1;
            if (!wp) wr_datamask = '0;
            if (!rp) rd_en = 1'b0;
        end
        wr_datamask = '0;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] pat;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        pat = {(DW/8){8'hA5}};
        xfer(1'b1, 64'h40, pat, '1, 1'b0, '0);
        xfer(1'b0, '0, '0, '0, 1'b1, 64'h40);
        wait_idle();

        xfer(1'b1, 64'h0, '1, '1, 1'b0, '0);
        xfer(1'b1, 64'h0, '0, 64'h1, 1'b0, '0);
        xfer(1'b0, '0, '0, '0, 1'b1, 64'h0);
        wait_idle();

        xfer(1'b1, 64'h40, rand_beat(), '1, 1'b1, 64'h40 + 64'(DEPTH * 64));
        wait_idle();

        for (int i = 0; i < 32; i++) xfer(1'b1, 64'(i * 64), rand_beat(), '1, 1'b0, '0);

        stream_rd(40, 64'h0);
        wait_idle();

        rand_phase(60, 100, 100);
        wait_idle();
        rand_phase(400, 50, 60);
        wait_idle();

        xfer(1'b0, '0, '0, '0, 1'b1, 64'h40);
        xfer(1'b0, '0, '0, '0, 1'b1, 64'h80);
        xfer(1'b0, '0, '0, '0, 1'b1, 64'hC0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        xfer(1'b0, '0, '0, '0, 1'b1, 64'h40);
        xfer(1'b0, '0, '0, '0, 1'b1, 64'h0);
        rand_phase(200, 40, 70);
        wait_idle();
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
